// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: immediate-extension mode encodings and default widths
package imm_ext_pkg;
   localparam logic [1:0] IMM_MODE_SIGN   = 2'd0;
   localparam logic [1:0] IMM_MODE_ZERO   = 2'd1;
   localparam logic [1:0] IMM_MODE_UPPER  = 2'd2;
   localparam logic [1:0] IMM_MODE_BRANCH = 2'd3;
   localparam int IMM_IN_W  = 16;
   localparam int IMM_OUT_W = 32;
endpackage

// File: rtl/imm_extend_pipe_core.sv
// imm_ext_core: combinational sign/zero/upper/branch extension of a narrow immediate
module imm_ext_core
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = IMM_IN_W,
   parameter int OUT_W = IMM_OUT_W
) (
   input  logic [IN_W-1:0]  imm_i,
   input  logic [1:0]       mode_i,
   output logic [OUT_W-1:0] ext_o
);
   if (OUT_W < IN_W + 2) begin : g_bad_width
      $error("imm_ext_core: OUT_W must be >= IN_W + 2");
   end
   logic [OUT_W-1:0] sext, zext;
   assign sext = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};
   assign zext = {{(OUT_W-IN_W){1'b0}}, imm_i};
   // shifts stay within OUT_W, so UPPER and BRANCH drop their overflowing MSBs
   always_comb begin
      ext_o = mode_i == IMM_MODE_SIGN  ? sext :
              mode_i == IMM_MODE_ZERO  ? zext :
              mode_i == IMM_MODE_UPPER ? zext << (OUT_W-IN_W) :
                                         sext << 2;
   end
endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate-extension stage with valid/ready handshake.
// Define IMM_EXT_SKID_EN to add a skid register and a registered in_ready.
module imm_extend_pipe
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = IMM_IN_W,
   parameter int OUT_W = IMM_OUT_W,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
);
   logic [OUT_W-1:0] ext;
   logic             valid_q, valid_d;
   logic [OUT_W-1:0] data_q, data_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             accept;

   imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
      .imm_i (in_imm),
      .mode_i(in_mode),
      .ext_o (ext)
   );

   assign accept    = in_valid && in_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_tag   = tag_q;

`ifdef IMM_EXT_SKID_EN
   logic             skid_valid_q, skid_valid_d;
   logic [OUT_W-1:0] skid_data_q, skid_data_d;
   logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

   assign in_ready = !skid_valid_q;

   // in_ready is low whenever the skid holds a beat, so skid refill and accept never coincide
   always_comb begin
      valid_d      = valid_q;
      data_d       = data_q;
      tag_d        = tag_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_tag_d   = skid_tag_q;
      if (!valid_q || out_ready) begin
         if (skid_valid_q) begin
            valid_d      = 1'b1;
            data_d       = skid_data_q;
            tag_d        = skid_tag_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            valid_d = 1'b1;
            data_d  = ext;
            tag_d   = in_tag;
         end else begin
            valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = ext;
         skid_tag_d   = in_tag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_tag_q   <= '0;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_tag_q   <= skid_tag_d;
      end
   end
`else
   assign in_ready = !valid_q || out_ready;

   always_comb begin
      valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : valid_q);
      data_d  = accept ? ext : data_q;
      tag_d   = accept ? in_tag : tag_q;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         tag_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         tag_q   <= tag_d;
      end
   end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed and randomized checks of imm_extend_pipe against a queue model
module tb_imm_extend_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid;
   logic [15:0] in_imm = '0;
   logic [1:0]  in_mode = '0;
   logic [4:0]  in_tag = '0, out_tag;
   logic [31:0] out_data;

   logic       s_in_valid = 1'b0, s_out_ready = 1'b0, s_in_ready, s_out_valid;
   logic [7:0] s_imm = '0;
   logic [1:0] s_mode = '0;
   logic [2:0] s_tag = '0, s_out_tag;
   logic [9:0] s_out_data;

   int checks = 0;
   int failures = 0;
   logic [36:0] q[$];

   always #5 clk = ~clk;

   imm_extend_pipe u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
      .in_mode(in_mode), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag)
   );

   imm_extend_pipe #(.IN_W(8), .OUT_W(10), .TAG_W(3)) u_small (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_imm(s_imm),
      .in_mode(s_mode), .in_tag(s_tag), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_data(s_out_data), .out_tag(s_out_tag)
   );

   // reference: treat the immediate as a signed/unsigned integer and do the arithmetic
   function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] m);
      longint u = longint'(imm);
      longint s = imm[15] ? u - 65536 : u;
      case (m)
         2'd0: return 32'(s);
         2'd1: return 32'(u);
         2'd2: return 32'(u * 65536);
         default: return 32'(s * 4);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [15:0] imm, input logic [1:0] m, input logic [4:0] t);
      in_valid = 1'b1;
      in_imm   = imm;
      in_mode  = m;
      in_tag   = t;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [36:0] head;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      tick;
      rst = 1'b0;
      tick;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      beat(16'h8001, 2'd0, 5'd7);
      tick;
      chk("sign_valid", 64'(out_valid), 64'd1);
      chk("sign_data", 64'(out_data), 64'hFFFF8001);
      chk("sign_tag", 64'(out_tag), 64'd7);

      out_ready = 1'b1;
      for (int m = 1; m < 4; m++) begin
         beat(16'h8001, 2'(m), 5'(m));
         tick;
         chk($sformatf("sweep_data_m%0d", m), 64'(out_data), 64'(ref_ext(16'h8001, 2'(m))));
         chk($sformatf("sweep_valid_m%0d", m), 64'(out_valid), 64'd1);
      end
      chk("sweep_zero_const", 64'(ref_ext(16'h8001, 2'd1)), 64'h00008001);
      chk("sweep_upper_const", 64'(ref_ext(16'h8001, 2'd2)), 64'h80010000);
      chk("sweep_branch_const", 64'(ref_ext(16'h8001, 2'd3)), 64'hFFFE0004);
      in_valid = 1'b0;
      tick;
      chk("drain_valid", 64'(out_valid), 64'd0);

      out_ready = 1'b0;
      beat(16'h1234, 2'd1, 5'd1);
      tick;
`ifdef IMM_EXT_SKID_EN
      chk("skid_a_in_ready", 64'(in_ready), 64'd1);
      beat(16'h5678, 2'd1, 5'd2);
      tick;
      in_valid = 1'b0;
      chk("skid_b_in_ready", 64'(in_ready), 64'd0);
      chk("skid_hold_a", 64'(out_data), 64'h1234);
      out_ready = 1'b1;
      #1;
      chk("skid_no_comb_ready", 64'(in_ready), 64'd0);
      tick;
      chk("skid_out_b", 64'(out_data), 64'h5678);
      chk("skid_out_b_tag", 64'(out_tag), 64'd2);
      chk("skid_ready_back", 64'(in_ready), 64'd1);
`else
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_hold_a", 64'(out_data), 64'h1234);
      beat(16'h5678, 2'd1, 5'd2);
      tick;
      chk("bp_still_a", 64'(out_data), 64'h1234);
      out_ready = 1'b1;
      #1;
      chk("bp_in_ready_comb", 64'(in_ready), 64'd1);
      tick;
      in_valid = 1'b0;
      chk("bp_out_b", 64'(out_data), 64'h5678);
`endif
      tick;
      chk("bp_drained", 64'(out_valid), 64'd0);

      out_ready = 1'b0;
      beat(16'hAAAA, 2'd0, 5'd3);
      tick;
      beat(16'h5555, 2'd0, 5'd4);
      tick;
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_data", 64'(out_data), 64'd0);
      #2 rst = 1'b0;
      out_ready = 1'b1;
      tick;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("post_rst_no_stale", 64'(out_valid), 64'd0);
      end

      s_out_ready = 1'b1;
      s_in_valid  = 1'b1;
      s_imm       = 8'h80;
      s_mode      = 2'd3;
      tick;
      chk("small_branch", 64'(s_out_data), 64'h200);
      s_imm  = 8'hA5;
      s_mode = 2'd2;
      tick;
      chk("small_upper", 64'(s_out_data), 64'h294);
      s_in_valid = 1'b0;

      for (int c = 0; c < 400; c++) begin
         in_valid  = 1'($urandom_range(0, 2) != 0);
         in_imm    = 16'($urandom);
         in_mode   = 2'($urandom);
         in_tag    = 5'($urandom);
         out_ready = 1'($urandom_range(0, 2) != 0);
         #1;
         chk("rnd_valid", 64'(out_valid), 64'(q.size() != 0));
         if (out_valid && out_ready && q.size() != 0) begin
            head = q.pop_front();
            chk("rnd_data", 64'({out_tag, out_data}), 64'(head));
         end
         if (in_valid && in_ready) q.push_back({in_tag, ref_ext(in_imm, in_mode)});
         chk("rnd_depth", 64'(q.size() <= 2), 64'd1);
         tick;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 8 && q.size() != 0; c++) begin
         #1;
         if (out_valid) begin
            head = q.pop_front();
            chk("drain_data", 64'({out_tag, out_data}), 64'(head));
         end
         tick;
      end
      chk("drain_empty", 64'(q.size()), 64'd0);
      tick;
      chk("final_idle", 64'(out_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
